rd_id_ex_stage: RTL
===================

# rd_id_ex_stage

ID/EX pipeline stage feeding the ALU top: registers one decoded instruction, resolves operand forwarding from the EX/MEM and MEM/WB stages, and presents the operand A, operand B, 4-bit funct and 2-bit ALUop that drive the ALU top.
- Owns load-use hazard detection: inserts one bubble when needed.
- Uses a valid/ready handshake on both sides so downstream stalls propagate upstream.

## Interface
- XLEN, 64, operand/data width
- RA, 5, register address width
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous reset, active-high
- id_valid_i  in  1  decode holds an instruction
- id_ready_o  out  1  stage accepts this cycle
- id_rs1_data_i, id_rs2_data_i  in  XLEN  register-file read data
- id_imm_i  in  XLEN  sign-extended immediate
- id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i  in  RA  register addresses
- id_funct_i  in  4  {funct7[5], funct3}
- id_aluop_i  in  2  ALUop from main control
- id_alusrc_i, id_regwrite_i, id_memread_i, id_memwrite_i, id_branch_i  in  1  control bits
- exm_regwrite_i, exm_memread_i  in  1  EX/MEM control
- exm_rd_addr_i  in  RA; exm_result_i  in  XLEN  EX/MEM destination and ALU result
- mwb_regwrite_i  in  1; mwb_rd_addr_i  in  RA; mwb_result_i  in  XLEN  MEM/WB writeback
- flush_i  in  1  synchronous squash (branch taken)
- ex_valid_o  out  1; ex_ready_i  in  1  downstream handshake
- ex_a_o, ex_b_o  out  XLEN  ALU operands
- ex_store_data_o  out  XLEN  forwarded rs2 for stores
- ex_funct_o  out  4; ex_aluop_o  out  2  to ALU control
- ex_rd_addr_o  out  RA; ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_branch_o  out  1  registered control
- bubble_cnt_o  out  32  count of load-use bubbles inserted, saturating

## Operation
- Stored entry fields:
  - valid
  - rs1/rs2 addr and data
  - imm
  - rd
  - funct
  - aluop
  - the five control bits
- Handshake signals:
  - fire_out = ex_valid_o & ex_ready_i
  - load_use = ex_valid_o & ex_memread_o & ex_rd_addr_o!=0 & (ex_rd_addr_o==id_rs1_addr_i | (ex_rd_addr_o==id_rs2_addr_i & (!id_alusrc_i | id_memwrite_i)))
  - id_ready_o = (!ex_valid_o | ex_ready_i) & !load_use
  - accept = id_valid_i & id_ready_o
- Next state:
  - flush_i: valid←0; overrides everything.
  - Else if accept: load the entry from ID, valid←1.
  - Else if fire_out: valid←0.
  - Else: hold.
- Capture bypass: on accept, rsN data ← mwb_result_i if mwb_regwrite_i & mwb_rd_addr_i==id_rsN_addr_i & addr!=0, else id_rsN_data_i.
- Hold snoop: while ex_valid_o & !fire_out, a matching mwb writeback (same condition, against the stored rsN addr) overwrites the stored rsN data.
- Output forwarding (combinational, per operand), fwdN priority:
  - 1: addr==0 → stored data.
  - 2: exm_regwrite_i & !exm_memread_i & exm_rd_addr_i==addr → exm_result_i.
  - 3: mwb_regwrite_i & mwb_rd_addr_i==addr → mwb_result_i.
  - 4: stored data.
- Operand outputs:
  - ex_a_o = fwd1.
  - ex_b_o = alusrc ? imm : fwd2.
  - ex_store_data_o = fwd2.
- Control outputs: all ex_* control outputs are stored fields and are not gated by valid.
- bubble_cnt_o increments by 1 on each cycle with fire_out & load_use & id_valid_i & !flush_i; holds at 0xFFFF_FFFF.

## Timing
- Reset (asynchronous): every stored field 0, so ex_valid_o=0, ex_a_o=ex_b_o=ex_store_data_o=0, ex_funct_o=0, ex_aluop_o=0, all control outputs 0, bubble_cnt_o=0, id_ready_o=1.
- Latency: an instruction accepted in cycle n appears valid at ex_* in cycle n+1.
- Throughput: one per cycle when ex_ready_i=1 and no hazard.
- Downstream stall: ex_ready_i=0 with valid entry → id_ready_o=0; entry and outputs hold stable except forwarded operand values.
- Load-use: exactly one bubble. ex_valid_o=0 in the cycle after the load leaves; the dependent instruction is accepted in that cycle and reaches EX while the load is in WB (MEM/WB forwarding).
- Simultaneous flush_i and accept: flush wins, nothing captured, ex_valid_o=0 next cycle.
- Simultaneous fire_out and accept: replace the entry, valid stays 1.
- Reset mid-operation: entry discarded immediately; no partial state survives.

## Test plan
- Back-to-back: add x3=x1+x2 (rs1=5, rs2=7), then addi x4=x3+10 with EX/MEM forwarding x3=12 → ex_a_o=12, ex_b_o=10, ex_funct_o/aluop passed through, one instruction per cycle.
- Forward priority: exm and mwb both target x5 (exm=0x11, mwb=0x22), rs1=x5 → ex_a_o=0x11; rs1=x0 with exm rd=0 writing 0x33 → ex_a_o=stored 0.
- Load-use: ld x6 in stage, next instruction add uses x6 → id_ready_o=0 for 1 cycle, one ex_valid_o=0 bubble, bubble_cnt_o=1; dependent gets mwb value 0xABCD.
- Stall with snoop: hold entry rs2=x8 for 3 cycles with ex_ready_i=0 while mwb writes x8=0x55, then release → ex_store_data_o=0x55 after mwb deasserted.
- Flush with accept: flush_i=1 and id_valid_i=1 same cycle → ex_valid_o=0 next cycle, no control bits latched as valid.
- Async reset mid-stall: assert rst_i between edges → ex_valid_o and all outputs 0 immediately, bubble_cnt_o=0, id_ready_o=1.

Source files
------------

// File: rtl/rd_id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: holds one decoded instruction, forwards operands
// from EX/MEM and MEM/WB, detects load-use hazards and handshakes with valid/ready on both sides.
module rd_id_ex_stage #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RA   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  output logic              id_ready_o,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [RA-1:0]     id_rs1_addr_i,
  input  logic [RA-1:0]     id_rs2_addr_i,
  input  logic [RA-1:0]     id_rd_addr_i,
  input  logic [3:0]        id_funct_i,
  input  logic [1:0]        id_aluop_i,
  input  logic              id_alusrc_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_memwrite_i,
  input  logic              id_branch_i,
  input  logic              exm_regwrite_i,
  input  logic              exm_memread_i,
  input  logic [RA-1:0]     exm_rd_addr_i,
  input  logic [XLEN-1:0]   exm_result_i,
  input  logic              mwb_regwrite_i,
  input  logic [RA-1:0]     mwb_rd_addr_i,
  input  logic [XLEN-1:0]   mwb_result_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [XLEN-1:0]   ex_a_o,
  output logic [XLEN-1:0]   ex_b_o,
  output logic [XLEN-1:0]   ex_store_data_o,
  output logic [3:0]        ex_funct_o,
  output logic [1:0]        ex_aluop_o,
  output logic [RA-1:0]     ex_rd_addr_o,
  output logic              ex_regwrite_o,
  output logic              ex_memread_o,
  output logic              ex_memwrite_o,
  output logic              ex_branch_o,
  output logic [31:0]       bubble_cnt_o
);

  logic              valid_q,    valid_d;
  logic [RA-1:0]     rs1_addr_q, rs1_addr_d;
  logic [RA-1:0]     rs2_addr_q, rs2_addr_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q,      imm_d;
  logic [RA-1:0]     rd_q,       rd_d;
  logic [3:0]        funct_q,    funct_d;
  logic [1:0]        aluop_q,    aluop_d;
  logic              alusrc_q,   alusrc_d;
  logic              regwrite_q, regwrite_d;
  logic              memread_q,  memread_d;
  logic              memwrite_q, memwrite_d;
  logic              branch_q,   branch_d;
  logic [31:0]       bubble_q,   bubble_d;

  logic              fire_out;
  logic              load_use;
  logic              id_ready;
  logic              accept;
  logic [XLEN-1:0]   cap_rs1;
  logic [XLEN-1:0]   cap_rs2;
  logic              snoop_rs1;
  logic              snoop_rs2;
  logic [XLEN-1:0]   fwd1;
  logic [XLEN-1:0]   fwd2;

  always_comb begin
    fire_out = valid_q & ex_ready_i;
    // rs2 only matters for the hazard when it is actually read: R-type operand or store data
    load_use = valid_q & memread_q & (rd_q != '0) &
               ((rd_q == id_rs1_addr_i) |
                ((rd_q == id_rs2_addr_i) & (!id_alusrc_i | id_memwrite_i)));
    id_ready = (!valid_q | ex_ready_i) & !load_use;
    accept   = id_valid_i & id_ready;
  end

  always_comb begin
    cap_rs1 = id_rs1_data_i;
    cap_rs2 = id_rs2_data_i;
    if (mwb_regwrite_i && (mwb_rd_addr_i == id_rs1_addr_i) && (id_rs1_addr_i != '0)) begin
      cap_rs1 = mwb_result_i;
    end
    if (mwb_regwrite_i && (mwb_rd_addr_i == id_rs2_addr_i) && (id_rs2_addr_i != '0)) begin
      cap_rs2 = mwb_result_i;
    end
    snoop_rs1 = mwb_regwrite_i && (mwb_rd_addr_i == rs1_addr_q) && (rs1_addr_q != '0);
    snoop_rs2 = mwb_regwrite_i && (mwb_rd_addr_i == rs2_addr_q) && (rs2_addr_q != '0);
  end

  always_comb begin
    valid_d    = valid_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rd_d       = rd_q;
    funct_d    = funct_q;
    aluop_d    = aluop_q;
    alusrc_d   = alusrc_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    branch_d   = branch_q;

    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      rs1_addr_d = id_rs1_addr_i;
      rs2_addr_d = id_rs2_addr_i;
      rs1_data_d = cap_rs1;
      rs2_data_d = cap_rs2;
      imm_d      = id_imm_i;
      rd_d       = id_rd_addr_i;
      funct_d    = id_funct_i;
      aluop_d    = id_aluop_i;
      alusrc_d   = id_alusrc_i;
      regwrite_d = id_regwrite_i;
      memread_d  = id_memread_i;
      memwrite_d = id_memwrite_i;
      branch_d   = id_branch_i;
    end else if (fire_out) begin
      valid_d = 1'b0;
    end

    // A stalled entry must not lose a writeback that retires while it waits
    if (valid_q && !fire_out && !accept) begin
      if (snoop_rs1) rs1_data_d = mwb_result_i;
      if (snoop_rs2) rs2_data_d = mwb_result_i;
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    if (fire_out && load_use && id_valid_i && !flush_i && (bubble_q != '1)) begin
      bubble_d = bubble_q + 32'd1;
    end
  end

  always_comb begin
    if (rs1_addr_q == '0) begin
      fwd1 = rs1_data_q;
    end else if (exm_regwrite_i && !exm_memread_i && (exm_rd_addr_i == rs1_addr_q)) begin
      fwd1 = exm_result_i;
    end else if (mwb_regwrite_i && (mwb_rd_addr_i == rs1_addr_q)) begin
      fwd1 = mwb_result_i;
    end else begin
      fwd1 = rs1_data_q;
    end

    if (rs2_addr_q == '0) begin
      fwd2 = rs2_data_q;
    end else if (exm_regwrite_i && !exm_memread_i && (exm_rd_addr_i == rs2_addr_q)) begin
      fwd2 = exm_result_i;
    end else if (mwb_regwrite_i && (mwb_rd_addr_i == rs2_addr_q)) begin
      fwd2 = mwb_result_i;
    end else begin
      fwd2 = rs2_data_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      funct_q    <= '0;
      aluop_q    <= '0;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      branch_q   <= 1'b0;
      bubble_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rd_q       <= rd_d;
      funct_q    <= funct_d;
      aluop_q    <= aluop_d;
      alusrc_q   <= alusrc_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      branch_q   <= branch_d;
      bubble_q   <= bubble_d;
    end
  end

  assign id_ready_o      = id_ready;
  assign ex_valid_o      = valid_q;
  assign ex_a_o          = fwd1;
  assign ex_b_o          = alusrc_q ? imm_q : fwd2;
  assign ex_store_data_o = fwd2;
  assign ex_funct_o      = funct_q;
  assign ex_aluop_o      = aluop_q;
  assign ex_rd_addr_o    = rd_q;
  assign ex_regwrite_o   = regwrite_q;
  assign ex_memread_o    = memread_q;
  assign ex_memwrite_o   = memwrite_q;
  assign ex_branch_o     = branch_q;
  assign bubble_cnt_o    = bubble_q;

endmodule
